// File: rtl/pwm_stream_decoder.sv
// Recovers the word behind a 1-bit duty-cycle stream by counting high samples
// over 2**CNT_W-cycle windows aligned to the stream's rising edge.
// Optional two-window rounding average: define PWM_DEC_AVG2_EN.
module pwm_stream_decoder #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              A_in,
  output logic [DATA_W-1:0] O_data,
  output logic              O_valid,
  output logic              O_locked,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;

  localparam logic [CNT_W-1:0] WIN_LAST = '1;

  logic              sync1_q, s_q, s_d_q;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  win_q, win_d;
  logic [CNT_W:0]    ones_q, ones_d;
  logic              rise0_q, rise0_d;
  logic              tog_q, tog_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;

  logic              rise, edge_seen;
  logic [CNT_W:0]    ones_sum, pub_val;

`ifdef PWM_DEC_AVG2_EN
  logic [CNT_W:0]    prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [CNT_W+1:0]  avg_sum;
`endif

  assign rise      = s_q & ~s_d_q;
  assign edge_seen = s_q ^ s_d_q;
  assign ones_sum  = ones_q + {{CNT_W{1'b0}}, s_q};

`ifdef PWM_DEC_AVG2_EN
  assign avg_sum = {1'b0, ones_sum} + {1'b0, prev_q} + {{(CNT_W+1){1'b0}}, 1'b1};
  assign pub_val = have_prev_q ? avg_sum[CNT_W+1:1] : ones_sum;
`else
  assign pub_val = ones_sum;
`endif

  // rise0 records a rising edge on sample 0; tog records any edge on samples
  // 1..WINDOW-1. Together they decide lock / re-arm at each window boundary.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ones_d   = ones_q;
    rise0_d  = rise0_q;
    tog_d    = tog_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
`ifdef PWM_DEC_AVG2_EN
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
`endif
    if (!en) begin
      state_d  = ST_IDLE;
      win_d    = '0;
      ones_d   = '0;
      rise0_d  = 1'b0;
      tog_d    = 1'b0;
      locked_d = 1'b0;
`ifdef PWM_DEC_AVG2_EN
      prev_d      = '0;
      have_prev_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (rise) begin
            state_d  = ST_COUNT;
            locked_d = 1'b1;
            win_d    = {{(CNT_W-1){1'b0}}, 1'b1};
            ones_d   = {{CNT_W{1'b0}}, 1'b1};
            rise0_d  = 1'b1;
            tog_d    = 1'b0;
          end else if (win_q == WIN_LAST) begin
            state_d  = ST_COUNT;
            locked_d = 1'b0;
            win_d    = '0;
            ones_d   = '0;
            rise0_d  = 1'b0;
            tog_d    = 1'b0;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
        ST_COUNT: begin
          if (win_q == WIN_LAST) begin
            valid_d = 1'b1;
            data_d  = DATA_W'(pub_val);
            win_d   = '0;
            ones_d  = '0;
            rise0_d = 1'b0;
            tog_d   = 1'b0;
`ifdef PWM_DEC_AVG2_EN
            prev_d      = ones_sum;
            have_prev_d = 1'b1;
`endif
            if (rise0_q) begin
              locked_d = 1'b1;
            end else if (tog_q | edge_seen) begin
              locked_d = 1'b0;
              state_d  = ST_ARM;
`ifdef PWM_DEC_AVG2_EN
              prev_d      = '0;
              have_prev_d = 1'b0;
`endif
            end else begin
              locked_d = 1'b0;
            end
          end else begin
            win_d  = win_q + 1'b1;
            ones_d = ones_sum;
            if (win_q == '0) rise0_d = rise;
            else             tog_d   = tog_q | edge_seen;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_d_q    <= 1'b0;
      state_q  <= ST_IDLE;
      win_q    <= '0;
      ones_q   <= '0;
      rise0_q  <= 1'b0;
      tog_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
`ifdef PWM_DEC_AVG2_EN
      prev_q      <= '0;
      have_prev_q <= 1'b0;
`endif
    end else begin
      sync1_q  <= A_in;
      s_q      <= sync1_q;
      s_d_q    <= s_q;
      state_q  <= state_d;
      win_q    <= win_d;
      ones_q   <= ones_d;
      rise0_q  <= rise0_d;
      tog_q    <= tog_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
`ifdef PWM_DEC_AVG2_EN
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
`endif
    end
  end

  assign O_data      = data_q;
  assign O_valid     = valid_q;
  assign O_locked    = locked_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pwm_stream_decoder.sv
// Randomized bench for pwm_stream_decoder (CNT_W = 4): each phase builds a
// stimulus table, predicts every result from the window rules, then checks per cycle.
module tb_pwm_stream_decoder;

  localparam int CNT_W    = 4;
  localparam int DATA_W   = 32;
  localparam int WIN      = 16;
  localparam int N        = 220;
  localparam int PHASES   = 18;
  localparam int EN_START = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              A_in = 1'b0;
  logic [DATA_W-1:0] O_data;
  logic              O_valid;
  logic              O_locked;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic        a_arr [N];
  logic        en_arr[N];
  logic        lk    [N];
  // {publish cycle[31:16], 7'b0, locked after publish[8], value[7:0]}
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  pwm_stream_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .A_in       (A_in),
    .O_data     (O_data),
    .O_valid    (O_valid),
    .O_locked   (O_locked),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp, input int cyc);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  // Sample seen by the decoder at edge k: A_in driven two edges earlier.
  function automatic logic xs(input int k);
    return (k >= 2) ? a_arr[k-2] : 1'b0;
  endfunction

  function automatic logic rs(input int k);
    return xs(k) & ~xs(k-1);
  endfunction

  function automatic void fill(input int from, input logic v, input int upto);
    for (int j = from; j < upto; j++) lk[j] = v;
  endfunction

  // Reference: walk each enabled span, find the aligned window start, sum
  // WIN samples, publish at the last sample, then decide keep/re-arm.
  function automatic void build_model();
    int  k, e, d, pos, start, pub, sum, val;
    bit  searching, found, r0, tog;
`ifdef PWM_DEC_AVG2_EN
    int  prev;
    bit  have_prev;
`endif
    exp_q.delete();
    for (int j = 0; j < N; j++) lk[j] = 1'b0;
    k = 0;
    while (k < N) begin
      if (!en_arr[k]) begin
        k++;
      end else begin
        e = k;
        d = k;
        while (d < N && en_arr[d]) d++;
        pos = e + 1;
        searching = 1;
        start = 0;
`ifdef PWM_DEC_AVG2_EN
        prev = 0;
        have_prev = 0;
`endif
        while (1) begin
          if (searching) begin
            found = 0;
            for (int j = pos; j <= pos + WIN - 1 && j < d; j++) begin
              if (rs(j)) begin
                start = j;
                found = 1;
                break;
              end
            end
            if (found) fill(start, 1'b1, d);
            else start = pos + WIN;
            searching = 0;
`ifdef PWM_DEC_AVG2_EN
            have_prev = 0;
`endif
          end
          pub = start + WIN - 1;
          if (pub >= d) break;
          sum = 0;
          tog = 0;
          for (int i = start; i <= pub; i++) begin
            sum += int'(xs(i));
            if (i > start && xs(i) != xs(i-1)) tog = 1;
          end
          r0  = rs(start);
          val = sum;
`ifdef PWM_DEC_AVG2_EN
          if (have_prev) val = (sum + prev + 1) / 2;
          prev = sum;
          have_prev = 1;
`endif
          exp_q.push_back({16'(pub), 7'd0, r0, 8'(val)});
          fill(pub, r0, d);
          if (r0 || !tog) start += WIN;
          else begin
            pos = start + WIN;
            searching = 1;
          end
        end
        k = d;
      end
    end
  endfunction

  // driver: stimulus table for one phase
  task automatic gen_phase(input int p);
    int kind, ph, h1, h2, per, k0, drop, len;
    logic cur;
    kind = p % 6;
    ph   = $urandom_range(0, 15);
    h1   = $urandom_range(1, 15);
    h2   = $urandom_range(1, 15);
    per  = $urandom_range(12, 20);
    if (p == 0) begin h1 = 4; ph = 0; end
    if (p == 3) begin h1 = 4; h2 = 9; end
    k0   = 96 - ph;
    drop = $urandom_range(40, 120);
    len  = $urandom_range(1, 20);
    cur  = 1'b0;
    for (int k = 0; k < N; k++) begin
      en_arr[k] = (k >= EN_START);
      if (kind == 5 && k >= drop && k < drop + len) en_arr[k] = 1'b0;
      case (kind)
        1: a_arr[k] = 1'b1;
        2: a_arr[k] = 1'b0;
        3: a_arr[k] = ((k + ph) % WIN) < ((k < k0) ? h1 : h2);
        4: begin
          if (p % 12 == 4) a_arr[k] = ((k + ph) % per) < (per / 3);
          else begin
            if ($urandom_range(0, 3) == 0) cur = ~cur;
            a_arr[k] = cur;
          end
        end
        default: a_arr[k] = ((k + ph) % WIN) < h1;
      endcase
    end
  endtask

  task automatic run_phase(input int p);
    logic [31:0] head, exp_hold;
    logic        exp_valid;
    gen_phase(p);
    build_model();
    // Reset lands mid-window of the previous phase; en high here must lose.
    rst_n = 1'b0;
    en    = 1'b1;
    A_in  = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    check("rst_data",   O_data,   32'd0, -1);
    check("rst_valid",  {31'd0, O_valid},  32'd0, -1);
    check("rst_locked", {31'd0, O_locked}, 32'd0, -1);
    check("rst_state",  {30'd0, dbg_state}, 32'd0, -1);
    @(posedge clk);
    @(negedge clk);
    exp_hold = 32'd0;
    for (int k = 0; k < N; k++) begin
      rst_n = 1'b1;
      en    = en_arr[k];
      A_in  = a_arr[k];
      @(posedge clk);
      @(negedge clk);
      exp_valid = 1'b0;
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        if (head[31:16] == 16'(k)) begin
          void'(exp_q.pop_front());
          exp_valid = 1'b1;
          exp_hold  = {24'd0, head[7:0]};
        end
      end
      check("valid",  {31'd0, O_valid},  {31'd0, exp_valid}, k);
      check("data",   O_data,            exp_hold,           k);
      check("locked", {31'd0, O_locked}, {31'd0, lk[k]},     k);
    end
    check("pending", 32'(exp_q.size()), 32'd0, N);
  endtask

  initial begin
    for (int p = 0; p < PHASES; p++) run_phase(p);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
